// File: rtl/bpsk_frame_builder.sv
// Frame builder ahead of the BPSK modulator: preamble, payload, optional zero tail.
// Build with BPSK_FRAME_TAIL_EN defined to append the encoder-flush tail.
module bpsk_frame_builder #(
  parameter int SPS = 8,
  parameter int PRE_LEN = 16,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 16'hF5A3,
  parameter int PAY_LEN = 64,
  parameter int TAIL_LEN = 6
) (
  input  logic clk_sig,
  input  logic reset_sig,
  input  logic start_sig,
  input  logic data_sig,
  input  logic data_valid_sig,
  output logic data_ready_sig,
  output logic bit_sig,
  output logic bit_valid_sig,
  output logic [$clog2(SPS)-1:0] sym_phase_sig,
  output logic busy_sig,
  output logic done_sig,
  output logic underrun_sig
);

  localparam int PW = $clog2(SPS);
  localparam int M1 = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
  localparam int MX = (M1 > TAIL_LEN) ? M1 : TAIL_LEN;
  localparam int CW = $clog2(MX + 1);

  localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAY_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
`ifdef BPSK_FRAME_TAIL_EN
  localparam logic [1:0] S_TAIL = 2'd3;
  localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_LEN - 1);
`endif

  logic [1:0]         r_state;
  logic [PW-1:0]      r_phase;
  logic [CW-1:0]      r_cnt;
  logic [PRE_LEN-1:0] r_shift;
  logic               r_bit;
  logic               r_done;
  logic               r_underrun;

  logic       w_sym_end;
  logic       w_last;
  logic       w_ready;
  logic [1:0] w_nxt;

  assign w_sym_end = (r_phase == PH_LAST);

  always_comb begin
    w_last = 1'b0;
    w_nxt  = S_IDLE;
    case (r_state)
      S_PRE: begin
        w_last = (r_cnt == PRE_LAST);
        w_nxt  = S_PAY;
      end
      S_PAY: begin
        w_last = (r_cnt == PAY_LAST);
`ifdef BPSK_FRAME_TAIL_EN
        w_nxt  = S_TAIL;
`else
        w_nxt  = S_IDLE;
`endif
      end
`ifdef BPSK_FRAME_TAIL_EN
      S_TAIL: begin
        w_last = (r_cnt == TAIL_LAST);
        w_nxt  = S_IDLE;
      end
`endif
      default: begin
        w_last = 1'b0;
        w_nxt  = S_IDLE;
      end
    endcase
  end

  // Fetch one symbol ahead: last preamble symbol and all but the last payload symbol.
  assign w_ready = w_sym_end &&
    (((r_state == S_PRE) && (r_cnt == PRE_LAST)) ||
     ((r_state == S_PAY) && (r_cnt != PAY_LAST)));

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bit      <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_phase <= '0;
        r_cnt   <= '0;
        r_bit   <= 1'b0;
        if (start_sig) begin
          r_state    <= S_PRE;
          r_underrun <= 1'b0;
          r_bit      <= PREAMBLE[PRE_LEN-1];
          r_shift    <= PREAMBLE << 1;
        end
      end else begin
        r_phase <= w_sym_end ? '0 : r_phase + 1'b1;
        if (w_sym_end) begin
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          r_shift <= r_shift << 1;
          r_bit   <= 1'b0;
          if ((r_state == S_PRE) && !w_last) begin
            r_bit <= r_shift[PRE_LEN-1];
          end
          if (w_ready) begin
            r_bit <= data_valid_sig & data_sig;
            if (!data_valid_sig) begin
              r_underrun <= 1'b1;
            end
          end
          if (w_last) begin
            r_state <= w_nxt;
            r_done  <= (w_nxt == S_IDLE);
          end
        end
      end
    end
  end

  assign busy_sig       = (r_state != S_IDLE);
  assign bit_valid_sig  = busy_sig && (r_phase == '0);
  assign sym_phase_sig  = r_phase;
  assign bit_sig        = r_bit;
  assign done_sig       = r_done;
  assign underrun_sig   = r_underrun;
  assign data_ready_sig = w_ready;

endmodule

// File: tb/tb_bpsk_frame_builder.sv
// Scoreboard bench for bpsk_frame_builder.
// Adapts the expected frame length to BPSK_FRAME_TAIL_EN.
module tb_bpsk_frame_builder;

  localparam int SPS = 4;
  localparam int PRE_LEN = 4;
  localparam int PAY_LEN = 8;
  localparam int TAIL_LEN = 2;
  localparam logic [3:0] PRE = 4'hB;
`ifdef BPSK_FRAME_TAIL_EN
  localparam int TL = TAIL_LEN;
`else
  localparam int TL = 0;
`endif
  localparam int FRAME = (PRE_LEN + PAY_LEN + TL) * SPS;

  logic clk_sig = 1'b0;
  logic reset_sig;
  logic start_sig;
  logic data_sig;
  logic data_valid_sig;
  logic data_ready_sig;
  logic bit_sig;
  logic bit_valid_sig;
  logic [1:0] sym_phase_sig;
  logic busy_sig;
  logic done_sig;
  logic underrun_sig;

  bpsk_frame_builder #(
    .SPS(SPS), .PRE_LEN(PRE_LEN), .PREAMBLE(PRE),
    .PAY_LEN(PAY_LEN), .TAIL_LEN(TAIL_LEN)
  ) dut (
    .clk_sig(clk_sig),
    .reset_sig(reset_sig),
    .start_sig(start_sig),
    .data_sig(data_sig),
    .data_valid_sig(data_valid_sig),
    .data_ready_sig(data_ready_sig),
    .bit_sig(bit_sig),
    .bit_valid_sig(bit_valid_sig),
    .sym_phase_sig(sym_phase_sig),
    .busy_sig(busy_sig),
    .done_sig(done_sig),
    .underrun_sig(underrun_sig)
  );

  always #5 clk_sig = ~clk_sig;

  int checks = 0;
  int errors = 0;
  logic q[$];
  logic [7:0] pay = 8'b1100_1010;
  int ph_model = 0;
  int drop_idx = -1;
  int rdy_cnt = 0;
  int busy_cyc = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int drop);
    for (int i = 0; i < PRE_LEN; i++) q.push_back(PRE[PRE_LEN-1-i]);
    for (int i = 0; i < PAY_LEN; i++)
      q.push_back((i + 1 == drop) ? 1'b0 : pay[7-i]);
    for (int i = 0; i < TL; i++) q.push_back(1'b0);
  endtask

  task automatic cycle();
    @(negedge clk_sig);
    if (busy_sig) begin
      chk("phase", sym_phase_sig, ph_model);
      chk("bvalid", bit_valid_sig, ph_model == 0);
      ph_model = (ph_model + 1) % SPS;
      busy_cyc++;
    end else begin
      ph_model = 0;
      chk("idle_bv", bit_valid_sig, 0);
    end
    if (bit_valid_sig) begin
      if (q.size() == 0) chk("extra_sym", 1, 0);
      else chk("bit", bit_sig, q.pop_front());
    end
    if (done_sig) begin
      done_cnt++;
      chk("done_idle", busy_sig, 0);
    end
    if (data_ready_sig) begin
      rdy_cnt++;
      data_valid_sig = (rdy_cnt != drop_idx);
      data_sig = pay[7-((rdy_cnt-1)%8)];
    end else begin
      data_valid_sig = 1'b1;
      data_sig = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bit"}, bit_sig, 0);
    chk({tag, "_bv"}, bit_valid_sig, 0);
    chk({tag, "_ph"}, sym_phase_sig, 0);
    chk({tag, "_busy"}, busy_sig, 0);
    chk({tag, "_done"}, done_sig, 0);
    chk({tag, "_und"}, underrun_sig, 0);
    chk({tag, "_rdy"}, data_ready_sig, 0);
  endtask

  task automatic run_frame(input int drop, input int poke);
    int n;
    drop_idx = drop;
    rdy_cnt = 0;
    busy_cyc = 0;
    done_cnt = 0;
    push_frame(drop);
    start_sig = 1'b1;
    cycle();
    start_sig = 1'b0;
    chk("start_busy", busy_sig, 1);
    chk("start_bv", bit_valid_sig, 1);
    chk("start_und", underrun_sig, 0);
    n = 1;
    while (done_cnt == 0 && n < 400) begin
      if (n == poke) start_sig = 1'b1;
      cycle();
      start_sig = 1'b0;
      n++;
    end
    chk("done_seen", done_cnt, 1);
    chk("busy_len", busy_cyc, FRAME);
    chk("handshakes", rdy_cnt, PAY_LEN);
    chk("q_empty", q.size(), 0);
  endtask

  initial begin
    int n;
    int dn;
    reset_sig = 1'b0;
    start_sig = 1'b0;
    data_sig = 1'b0;
    data_valid_sig = 1'b1;
    cycle();
    chk_zero("rst");
    reset_sig = 1'b1;
    repeat (3) cycle();

    run_frame(-1, 0);
    chk("basic_und", underrun_sig, 0);
    repeat (3) cycle();

    run_frame(3, 0);
    repeat (3) cycle();
    chk("und_sticky", underrun_sig, 1);

    drop_idx = -1;
    rdy_cnt = 0;
    busy_cyc = 0;
    done_cnt = 0;
    push_frame(-1);
    push_frame(-1);
    start_sig = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      cycle();
      n++;
    end
    chk("b2b_done1", done_cnt, 1);
    cycle();
    chk("b2b_gap_bv", bit_valid_sig, 1);
    chk("b2b_busy", busy_sig, 1);
    chk("b2b_und", underrun_sig, 0);
    n = 0;
    while (done_cnt < 2 && n < 400) begin
      cycle();
      n++;
    end
    start_sig = 1'b0;
    chk("b2b_done2", done_cnt, 2);
    chk("b2b_len", busy_cyc, 2 * FRAME);
    chk("b2b_hs", rdy_cnt, 2 * PAY_LEN);
    chk("b2b_q", q.size(), 0);
    repeat (3) cycle();
    chk("b2b_idle", busy_sig, 0);

    run_frame(-1, 10);
    repeat (30) cycle();
    chk("sb_done", done_cnt, 1);
    chk("sb_idle", busy_sig, 0);

    done_cnt = 0;
    drop_idx = -1;
    push_frame(-1);
    start_sig = 1'b1;
    cycle();
    start_sig = 1'b0;
    repeat (19) cycle();
    chk("mr_busy", busy_sig, 1);
    #1 reset_sig = 1'b0;
    #1 chk_zero("mr");
    dn = done_cnt;
    repeat (3) cycle();
    reset_sig = 1'b1;
    q.delete();
    repeat (10) cycle();
    chk("mr_nodone", done_cnt, dn);
    run_frame(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
